addsub_accumulator: RTL and testbench

- Sequential stage directly downstream of the n-bit adder/subtractor.
- Holds an n-bit accumulator that drives the adder's `x` operand. Takes an operand and opcode over a valid/ready command channel, and registers the adder's `s` and `cout` back into the accumulator.
- Returns result plus carry/overflow/zero flags over a valid/ready response channel.
- Used as the datapath register stage for ALU-style command sequencing.

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/adder_substractor_nbit.sv | 17 +
 rtl/addsub_accumulator.sv | 130 +++++++++++++
 tb/tb_addsub_accumulator.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the add/sub accumulator: command opcodes and FSM states.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_CLR  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ADD  = 2'd2,
    OP_SUB  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_is_sub(input op_t op);
    return (op == OP_SUB);
  endfunction

endpackage

// File: rtl/adder_substractor_nbit.sv
// n-bit ripple adder/subtractor: s = x + y (add_n=0) or x - y (add_n=1, y inverted, add_n as carry-in).
module adder_substractor_nbit #(
  parameter int n = 8
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         cout
);

  logic [n-1:0] y_eff;

  assign y_eff     = y ^ {n{add_n}};
  assign {cout, s} = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};

endmodule

// File: rtl/addsub_accumulator.sv
// Accumulator register stage behind the adder/subtractor, with valid/ready command and response channels.
// Optional signed saturation on ADD/SUB overflow when ADDSUB_ACC_SATURATE_EN is defined.
//
//   state  | meaning
//   S_IDLE | cmd_ready=1, capture op/data on cmd_valid
//   S_EXEC | write adder result and flags into acc/flag registers
//   S_RESP | res_valid=1, hold outputs until res_ready
module addsub_accumulator
  import addsub_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [n-1:0] cmd_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [n-1:0] res_data,
  output logic         res_carry,
  output logic         res_ovf,
  output logic         res_zero
);

  state_t       state, state_nxt;
  op_t          op_q;
  logic [n-1:0] data_q;
  logic [n-1:0] acc, acc_nxt;
  logic         carry_q, carry_nxt;
  logic         ovf_q, ovf_nxt;
  logic         zero_q;

  logic         add_n;
  logic [n-1:0] sum;
  logic         cout;
  logic [n-1:0] y_eff;
  logic         ovf_raw;
  logic [n-1:0] arith_res;

  assign add_n = op_is_sub(op_q);

  adder_substractor_nbit #(.n(n)) u_addsub (
    .x     (acc),
    .y     (data_q),
    .add_n (add_n),
    .s     (sum),
    .cout  (cout)
  );

  assign y_eff   = data_q ^ {n{add_n}};
  assign ovf_raw = (acc[n-1] == y_eff[n-1]) && (sum[n-1] != acc[n-1]);

`ifdef ADDSUB_ACC_SATURATE_EN
  // Clamp toward the sign of the old accumulator: overflow only happens when both operands share it.
  logic [n-1:0] sat_limit;
  assign sat_limit = acc[n-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
  assign arith_res = ovf_raw ? sat_limit : sum;
`else
  assign arith_res = sum;
`endif

  always_comb begin
    acc_nxt   = acc;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    unique case (op_q)
      OP_CLR:  acc_nxt = '0;
      OP_LOAD: acc_nxt = data_q;
      OP_ADD, OP_SUB: begin
        acc_nxt   = arith_res;
        carry_nxt = cout;
        ovf_nxt   = ovf_raw;
      end
      default: acc_nxt = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_CLR;
      data_q <= '0;
    end else if (state == S_IDLE && cmd_valid) begin
      op_q   <= op_t'(cmd_op);
      data_q <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state == S_EXEC) begin
      acc     <= acc_nxt;
      carry_q <= carry_nxt;
      ovf_q   <= ovf_nxt;
      zero_q  <= (acc_nxt == '0);
    end
  end

  // Ready is masked by rst so it only rises once reset is released.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign res_valid = (state == S_RESP);
  assign res_data  = acc;
  assign res_carry = carry_q;
  assign res_ovf   = ovf_q;
  assign res_zero  = zero_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator: reference model feeds a scoreboard queue checked on each response.
module tb_addsub_accumulator;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_carry;
  logic         res_ovf;
  logic         res_zero;

  addsub_accumulator #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .res_zero  (res_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       carry;
    logic       ovf;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] acc_m;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done with plain signed/unsigned integers.
  task automatic push_exp(input logic [1:0] op, input logic [7:0] d);
    exp_t e;
    int   xs, ys, r;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.data  = 8'h00;
    case (op)
      2'd0: e.data = 8'h00;
      2'd1: e.data = d;
      default: begin
        xs = $signed(acc_m);
        ys = $signed(d);
        r  = (op == 2'd3) ? xs - ys : xs + ys;
        e.ovf   = (r > 127) || (r < -128);
        e.carry = (op == 2'd3) ? (acc_m >= d) : ((int'(acc_m) + int'(d)) > 255);
        e.data  = r[7:0];
`ifdef ADDSUB_ACC_SATURATE_EN
        if (e.ovf) e.data = (xs >= 0) ? 8'h7F : 8'h80;
`endif
      end
    endcase
    e.zero = (e.data == 8'h00);
    acc_m  = e.data;
    sb.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    push_exp(op, d);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    chk("lat_exec_valid", res_valid, 0);
    chk("exec_ready", cmd_ready, 0);
    @(negedge clk);
    chk("lat_resp_valid", res_valid, 1);
  endtask

  task automatic recv(input int stall);
    exp_t       e;
    logic [7:0] d0;
    logic [2:0] f0;
    d0 = res_data;
    f0 = {res_carry, res_ovf, res_zero};
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'($urandom);
      cmd_data  = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", res_valid, 1);
      chk("stall_ready", cmd_ready, 0);
      chk("stall_data", res_data, d0);
      chk("stall_flags", {res_carry, res_ovf, res_zero}, f0);
    end
    cmd_valid = 1'b0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=response expected=none");
    end else begin
      e = sb.pop_front();
      chk("res_data", res_data, e.data);
      chk("res_carry", res_carry, e.carry);
      chk("res_ovf", res_ovf, e.ovf);
      chk("res_zero", res_zero, e.zero);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("idle_valid", res_valid, 0);
    chk("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 8'h00;
    res_ready = 1'b0;
    acc_m     = 8'h00;
    #1 rst = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_hold_valid", res_valid, 0);
    chk("rst_hold_data", res_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 8'h00);
    chk("rst_flags", {res_carry, res_ovf, res_zero}, 3'b000);
    chk("rst_ready", cmd_ready, 1);

    // unsigned carry
    send(2'd1, 8'hFF); recv(0);
    send(2'd2, 8'h01); recv(0);
    // signed overflow
    send(2'd1, 8'h7F); recv(0);
    send(2'd2, 8'h01); recv(0);
    // subtract
    send(2'd1, 8'h05); recv(0);
    send(2'd3, 8'h05); recv(0);
    send(2'd3, 8'h01); recv(0);
    send(2'd1, 8'h80); recv(0);
    send(2'd3, 8'h01); recv(0);
    // clear, then backpressure with a live cmd_valid stream
    send(2'd0, 8'hA5); recv(0);
    send(2'd2, 8'h33); recv(5);
    send(2'd2, 8'h01); recv(0);
    send(2'd3, 8'h90); recv(0);

    // reset while a response is stalled
    send(2'd1, 8'h20); recv(0);
    send(2'd2, 8'h10);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", res_valid, 0);
    chk("async_data", res_data, 8'h00);
    chk("async_flags", {res_carry, res_ovf, res_zero}, 3'b000);
    sb.delete();
    acc_m = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_valid", res_valid, 0);
    send(2'd2, 8'h05); recv(0);
    send(2'd1, 8'h03); recv(0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
